// File: rtl/seg_pkg.sv
// Shared types and glyph constants for the 4-digit multiplexed 7-segment driver.
// Segment vectors are {g,f,e,d,c,b,a}, active-low.
package seg_pkg;

  typedef enum logic [1:0] {StIdle, StBlank, StOn} state_e;

  localparam int unsigned NUM_DIGITS = 4;

  typedef logic [NUM_DIGITS-1:0][3:0] digits_t;

  localparam logic [6:0] SEG_OFF  = 7'h7F;
  localparam logic [6:0] SEG_DASH = 7'h3F;

  // Index 9 is the most significant entry.
  localparam logic [9:0][6:0] GLYPHS = {
    7'h10, 7'h00, 7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage

// File: rtl/seg_scan_driver_if.sv
// Digit-input and display-pin bundle of the scan driver.
// master: digit source side; slave: the driver itself.
interface seg_scan_driver_if;
  logic       en;
  logic       load;
  logic [3:0] d0;
  logic [3:0] d1;
  logic [3:0] d2;
  logic [3:0] d3;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       frame;

  modport master (
    output en, load, d0, d1, d2, d3,
    input  an, seg, dp, frame
  );

  modport slave (
    input  en, load, d0, d1, d2, d3,
    output an, seg, dp, frame
  );
endinterface

// File: rtl/seg7_decode.sv
// Combinational BCD to active-low 7-segment lookup; 10..15 render as a dash
// so transient out-of-range counts never show garbage.
module seg7_decode
  import seg_pkg::*;
(
  input  logic [3:0] val_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_DASH;
    if (val_i < 4'd10) seg_o = GLYPHS[val_i];
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed 4-digit common-anode display driver with per-slot blanking
// and frame-synchronous double buffering. Optional macro: LEADING_ZERO_BLANK_EN.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int unsigned SCAN_DIV  = 100000,
  parameter int unsigned BLANK_CYC = 1000,
  parameter int          DP_POS    = 2
) (
  input logic              clk,
  input logic              rst,
  seg_scan_driver_if.slave bus
);

  localparam int unsigned     CntW      = $clog2(SCAN_DIV);
  localparam logic [CntW-1:0] BlankLast = CntW'(BLANK_CYC - 1);
  localparam logic [CntW-1:0] SlotLast  = CntW'(SCAN_DIV - 1);
  localparam bit              DpEn      = (DP_POS >= 0) && (DP_POS <= 3);
  localparam logic [1:0]      DpSlot    = 2'(DP_POS);

  state_e          state_q, state_d;
  logic [1:0]      slot_q, slot_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            xfer;

  digits_t active_q, active_d, pending_q, pending_d;
  logic    pend_valid_q, pend_valid_d;
  digits_t din;

  logic [3:0] an_q, an_d;
  logic [6:0] seg_q, seg_d, glyph;
  logic       dp_q, dp_d, frame_q, frame_d;
  logic       blank_digit;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      slot_q  <= 2'd0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      cnt_q   <= cnt_d;
    end
  end

  // xfer marks the edge entering BLANK of slot 0, where the buffer swaps.
  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    cnt_d   = cnt_q;
    xfer    = 1'b0;
    if (!bus.en) begin
      state_d = StIdle;
      slot_d  = 2'd0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_d = StBlank;
          slot_d  = 2'd0;
          cnt_d   = '0;
          xfer    = 1'b1;
        end
        StBlank: begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == BlankLast) state_d = StOn;
        end
        StOn: begin
          if (cnt_q == SlotLast) begin
            state_d = StBlank;
            slot_d  = slot_q + 2'd1;
            cnt_d   = '0;
            xfer    = (slot_q == 2'd3);
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  assign din = {bus.d3, bus.d2, bus.d1, bus.d0};

  always_comb begin
    active_d     = active_q;
    pending_d    = pending_q;
    pend_valid_d = pend_valid_q;
    if (xfer) begin
      if (bus.load)          active_d = din;
      else if (pend_valid_q) active_d = pending_q;
      pend_valid_d = 1'b0;
    end else if (bus.load) begin
      pending_d    = din;
      pend_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      active_q     <= '0;
      pending_q    <= '0;
      pend_valid_q <= 1'b0;
    end else begin
      active_q     <= active_d;
      pending_q    <= pending_d;
      pend_valid_q <= pend_valid_d;
    end
  end

  seg7_decode u_decode (
    .val_i (active_d[slot_d]),
    .seg_o (glyph)
  );

`ifdef LEADING_ZERO_BLANK_EN
  logic [NUM_DIGITS-1:0] lead_zero;
  always_comb begin
    lead_zero[3] = (active_d[3] == 4'd0);
    lead_zero[2] = lead_zero[3] && (active_d[2] == 4'd0);
    lead_zero[1] = lead_zero[2] && (active_d[1] == 4'd0);
    lead_zero[0] = 1'b0;
  end
  assign blank_digit = lead_zero[slot_d];
`else
  assign blank_digit = 1'b0;
`endif

  // Outputs are computed from next-state so they change on the same edge as the FSM.
  always_comb begin
    an_d    = 4'hF;
    seg_d   = SEG_OFF;
    dp_d    = 1'b1;
    frame_d = xfer;
    if (state_d != StIdle) begin
      seg_d = blank_digit ? SEG_OFF : glyph;
      dp_d  = !(DpEn && (slot_d == DpSlot));
      if (state_d == StOn) an_d = ~(4'b0001 << slot_d);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      an_q    <= 4'hF;
      seg_q   <= SEG_OFF;
      dp_q    <= 1'b1;
      frame_q <= 1'b0;
    end else begin
      an_q    <= an_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
      frame_q <= frame_d;
    end
  end

  assign bus.an    = an_q;
  assign bus.seg   = seg_q;
  assign bus.dp    = dp_q;
  assign bus.frame = frame_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed self-checking bench for seg_scan_driver with SCAN_DIV=8, BLANK_CYC=2,
// DP_POS=2; honours LEADING_ZERO_BLANK_EN when defined.
module tb_seg_scan_driver;

  localparam logic [6:0] G0 = 7'h40, G1 = 7'h79, G2 = 7'h24, G3 = 7'h30, G4 = 7'h19;
  localparam logic [6:0] G5 = 7'h12, G6 = 7'h02, G7 = 7'h78, G8 = 7'h00, G9 = 7'h10;
  localparam logic [6:0] GD = 7'h3F, GOFF = 7'h7F;
`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [6:0] GZ = GOFF;
`else
  localparam logic [6:0] GZ = G0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;

  seg_scan_driver_if bus ();

  seg_scan_driver #(
    .SCAN_DIV  (8),
    .BLANK_CYC (2),
    .DP_POS    (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [3:0] an_e, input logic [6:0] seg_e,
                         input logic dp_e, input logic fr_e);
    chk({tag, ".an"}, 7'(bus.an), 7'(an_e));
    chk({tag, ".seg"}, bus.seg, seg_e);
    chk({tag, ".dp"}, 7'(bus.dp), 7'(dp_e));
    chk({tag, ".frame"}, 7'(bus.frame), 7'(fr_e));
  endtask

  // One slot: 2 blank cycles then 6 on cycles; optional load strobe before step ld_k.
  task automatic run_slot(input string tag, input logic [3:0] an_on, input logic [6:0] seg_e,
                          input logic dp_e, input logic fr_e, input int ld_k,
                          input logic [15:0] ldv);
    for (int k = 0; k < 8; k++) begin
      if (k == ld_k) begin
        bus.load = 1'b1;
        {bus.d3, bus.d2, bus.d1, bus.d0} = ldv;
      end
      step();
      bus.load = 1'b0;
      chk_out($sformatf("%s.k%0d", tag, k), (k < 2) ? 4'hF : an_on, seg_e, dp_e,
              (k == 0) ? fr_e : 1'b0);
    end
  endtask

  task automatic run_frame(input string tag, input logic [6:0] g0, input logic [6:0] g1,
                           input logic [6:0] g2, input logic [6:0] g3, input int ld_slot,
                           input int ld_k, input logic [15:0] ldv);
    run_slot({tag, ".s0"}, 4'hE, g0, 1'b1, 1'b1, (ld_slot == 0) ? ld_k : -1, ldv);
    run_slot({tag, ".s1"}, 4'hD, g1, 1'b1, 1'b0, (ld_slot == 1) ? ld_k : -1, ldv);
    run_slot({tag, ".s2"}, 4'hB, g2, 1'b0, 1'b0, (ld_slot == 2) ? ld_k : -1, ldv);
    run_slot({tag, ".s3"}, 4'h7, g3, 1'b1, 1'b0, (ld_slot == 3) ? ld_k : -1, ldv);
  endtask

  initial begin
    rst      = 1'b1;
    bus.en   = 1'b1;
    bus.load = 1'b0;
    bus.d0   = 4'd0;
    bus.d1   = 4'd0;
    bus.d2   = 4'd0;
    bus.d3   = 4'd0;

    for (int i = 0; i < 3; i++) begin
      step();
      chk_out($sformatf("reset%0d", i), 4'hF, GOFF, 1'b1, 1'b0);
    end
    rst = 1'b0;

    // Post-reset frame shows zeros; load 1,2,3,4 mid-frame stays pending.
    run_frame("rst_frame", G0, G0, G0, G0, 2, 3, 16'h1234);
    // New digits appear; load 5,6,7,8 in slot 1 must wait for the next frame.
    run_frame("scan", G4, G3, G2, G1, 1, 4, 16'h5678);
    // Two loads in one frame: only the second (9,8,7,6) survives.
    run_slot("sync.s0", 4'hE, G8, 1'b1, 1'b1, -1, 16'h0);
    run_slot("sync.s1", 4'hD, G7, 1'b1, 1'b0, 3, 16'h2222);
    run_slot("sync.s2", 4'hB, G6, 1'b0, 1'b0, -1, 16'h0);
    run_slot("sync.s3", 4'h7, G5, 1'b1, 1'b0, 5, 16'h9876);
    run_frame("multi", G6, G7, G8, G9, -1, -1, 16'h0);
    // Load on the transfer edge bypasses into this frame; d0=10 shows a dash.
    run_frame("bypass", GD, G4, G1, G3, 0, 0, 16'h314A);
    run_frame("bypass_b", GD, G4, G1, G3, 2, 3, 16'h0007);
    run_frame("lzero", G7, GZ, GZ, GZ, -1, -1, 16'h0);

    // Enable drop during slot 1 ON.
    run_slot("endrop.s0", 4'hE, G7, 1'b1, 1'b1, -1, 16'h0);
    step();
    step();
    step();
    chk_out("endrop.on", 4'hD, GZ, 1'b1, 1'b0);
    bus.en = 1'b0;
    step();
    chk_out("endrop.dark0", 4'hF, GOFF, 1'b1, 1'b0);
    step();
    chk_out("endrop.dark1", 4'hF, GOFF, 1'b1, 1'b0);
    bus.en = 1'b1;
    run_frame("restart", G7, GZ, GZ, GZ, -1, -1, 16'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
